// File: rtl/regfile_mp.sv
// Multi-ported register file with two registered read ports, two write ports
// (M beats E on collision), optional write-to-read forwarding and a busy scoreboard.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic              rdA_en,
  input  logic              rdB_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic              wrE,
  input  logic              wrM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              hazA,
  output logic              hazB,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0] regs_r     [NREG];
  logic [DATA_W-1:0] regs_nxt_s [NREG];
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic [NREG-1:0]   wr_hit_s;
  logic [NREG-1:0]   iss_hit_s;
  logic [NREG-1:0]   clr_s;
  logic [DATA_W-1:0] rdA_data_s;
  logic [DATA_W-1:0] rdB_data_s;
  logic              rdA_haz_s;
  logic              rdB_haz_s;

  // Next array and scoreboard state; an issue to a register overrides its clearing write.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_nxt_s[r] = regs_r[r];
      busy_nxt_s[r] = busy_r[r];
      iss_hit_s[r]  = iss_en && (iss_dst == ADDR_W'(r));
      wr_hit_s[r]   = (wrE && (dstE == ADDR_W'(r))) || (wrM && (dstM == ADDR_W'(r)));
      clr_s[r]      = wr_hit_s[r] && !iss_hit_s[r];
      if (wrM && (dstM == ADDR_W'(r))) begin
        regs_nxt_s[r] = valM;
      end else if (wrE && (dstE == ADDR_W'(r))) begin
        regs_nxt_s[r] = valE;
      end else begin
        regs_nxt_s[r] = regs_r[r];
      end
      if (iss_hit_s[r]) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_hit_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Read-port data and hazard; forwarding reads the post-write value of the array.
  always_comb begin
    rdA_data_s = {DATA_W{1'b0}};
    rdB_data_s = {DATA_W{1'b0}};
    rdA_haz_s  = 1'b0;
    rdB_haz_s  = 1'b0;
    if (rdA_en) begin
      rdA_data_s = BYP ? regs_nxt_s[srcA] : regs_r[srcA];
      rdA_haz_s  = busy_r[srcA] && !(BYP && clr_s[srcA]);
    end else begin
      rdA_data_s = {DATA_W{1'b0}};
      rdA_haz_s  = 1'b0;
    end
    if (rdB_en) begin
      rdB_data_s = BYP ? regs_nxt_s[srcB] : regs_r[srcB];
      rdB_haz_s  = busy_r[srcB] && !(BYP && clr_s[srcB]);
    end else begin
      rdB_data_s = {DATA_W{1'b0}};
      rdB_haz_s  = 1'b0;
    end
  end

  // State update; stall freezes only the read-port outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
      end
      busy_r <= {NREG{1'b0}};
      valA   <= {DATA_W{1'b0}};
      valB   <= {DATA_W{1'b0}};
      hazA   <= 1'b0;
      hazB   <= 1'b0;
    end else begin
      regs_r <= regs_nxt_s;
      busy_r <= busy_nxt_s;
      if (!stall) begin
        valA <= rdA_data_s;
        valB <= rdB_data_s;
        hazA <= rdA_haz_s;
        hazB <= rdB_haz_s;
      end
    end
  end

  assign dbg_data = regs_r[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared every cycle against an array-level model, plus literal expectations.
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        reset;
  logic [2:0]  srcA, srcB, dstE, dstM, iss_dst, dbg_addr;
  logic        rdA_en, rdB_en, stall, wrE, wrM, iss_en;
  logic [31:0] valE, valM;
  logic [31:0] valA_b, valB_b, dbg_b, valA_n, valB_n, dbg_n;
  logic        hazA_b, hazB_b, hazA_n, hazB_n;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // model state; index 1 = forwarding instance, 0 = non-forwarding
  logic [31:0] m_regs [8];
  logic [7:0]  m_busy;
  logic [31:0] e_valA [2];
  logic [31:0] e_valB [2];
  logic        e_hazA [2];
  logic        e_hazB [2];

  always #5 CLK = ~CLK;

  regfile_mp #(.DATA_W(32), .ADDR_W(3), .BYPASS(1)) u_byp (
    .CLK(CLK), .reset(reset), .srcA(srcA), .srcB(srcB), .rdA_en(rdA_en), .rdB_en(rdB_en),
    .stall(stall), .dstE(dstE), .dstM(dstM), .wrE(wrE), .wrM(wrM), .valE(valE), .valM(valM),
    .iss_en(iss_en), .iss_dst(iss_dst), .valA(valA_b), .valB(valB_b), .hazA(hazA_b),
    .hazB(hazB_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  regfile_mp #(.DATA_W(32), .ADDR_W(3), .BYPASS(0)) u_nob (
    .CLK(CLK), .reset(reset), .srcA(srcA), .srcB(srcB), .rdA_en(rdA_en), .rdB_en(rdB_en),
    .stall(stall), .dstE(dstE), .dstM(dstM), .wrE(wrE), .wrM(wrM), .valE(valE), .valM(valM),
    .iss_en(iss_en), .iss_dst(iss_dst), .valA(valA_n), .valB(valB_n), .hazA(hazA_n),
    .hazB(hazB_n), .dbg_addr(dbg_addr), .dbg_data(dbg_n));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_data(input int bp, input logic [2:0] a, input logic en);
    logic [31:0] d;
    if (!en) return 32'd0;
    d = m_regs[a];
    if (bp == 1) begin
      if (wrE && dstE == a) d = valE;
      if (wrM && dstM == a) d = valM;
    end
    return d;
  endfunction

  function automatic logic m_haz(input int bp, input logic [2:0] a, input logic en);
    logic written;
    if (!en) return 1'b0;
    written = (wrE && dstE == a) || (wrM && dstM == a);
    if (bp == 1 && written && !(iss_en && iss_dst == a)) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 32'd0;
      m_busy <= 8'd0;
      for (int b = 0; b < 2; b++) begin
        e_valA[b] <= 32'd0; e_valB[b] <= 32'd0; e_hazA[b] <= 1'b0; e_hazB[b] <= 1'b0;
      end
    end else begin
      if (!stall) begin
        for (int b = 0; b < 2; b++) begin
          e_valA[b] <= m_data(b, srcA, rdA_en);
          e_valB[b] <= m_data(b, srcB, rdB_en);
          e_hazA[b] <= m_haz(b, srcA, rdA_en);
          e_hazB[b] <= m_haz(b, srcB, rdB_en);
        end
      end
      // later assignments win: M over E, issue over clear
      if (wrE) m_regs[dstE] <= valE;
      if (wrM) m_regs[dstM] <= valM;
      if (wrE) m_busy[dstE] <= 1'b0;
      if (wrM) m_busy[dstM] <= 1'b0;
      if (iss_en) m_busy[iss_dst] <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("valA_byp", valA_b, e_valA[1]);
      chk("valB_byp", valB_b, e_valB[1]);
      chk("hazA_byp", {31'd0, hazA_b}, {31'd0, e_hazA[1]});
      chk("hazB_byp", {31'd0, hazB_b}, {31'd0, e_hazB[1]});
      chk("valA_nob", valA_n, e_valA[0]);
      chk("valB_nob", valB_n, e_valB[0]);
      chk("hazA_nob", {31'd0, hazA_n}, {31'd0, e_hazA[0]});
      chk("hazB_nob", {31'd0, hazB_n}, {31'd0, e_hazB[0]});
      chk("dbg_byp", dbg_b, m_regs[dbg_addr]);
      chk("dbg_nob", dbg_n, m_regs[dbg_addr]);
    end
  end

  task automatic idle();
    srcA = 3'd0; srcB = 3'd0; rdA_en = 1'b0; rdB_en = 1'b0; stall = 1'b0;
    dstE = 3'd0; dstM = 3'd0; wrE = 1'b0; wrM = 1'b0; valE = 32'd0; valM = 32'd0;
    iss_en = 1'b0; iss_dst = 3'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    dbg_addr = 3'd0;
    idle();
    #1 reset = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_valA", valA_b, 32'h0);
    chk("rst_hazB", {31'd0, hazB_n}, 32'h0);
    reset = 1'b1;

    // same-cycle write and read of register 2
    wrE = 1'b1; dstE = 3'd2; valE = 32'h1234; srcA = 3'd2; rdA_en = 1'b1;
    tick();
    chk("fwd_byp", valA_b, 32'h1234);
    chk("fwd_nob", valA_n, 32'h0);
    idle(); srcA = 3'd2; rdA_en = 1'b1;
    tick();
    chk("rd2_nob", valA_n, 32'h1234);

    // E/M collision on register 5
    idle(); wrE = 1'b1; dstE = 3'd5; valE = 32'hAAAA; wrM = 1'b1; dstM = 3'd5; valM = 32'h5555;
    tick();
    idle(); dbg_addr = 3'd5; srcB = 3'd5; rdB_en = 1'b1;
    tick();
    chk("coll_dbg", dbg_b, 32'h5555);
    chk("coll_rd", valB_n, 32'h5555);

    // scoreboard set then cleared by M write
    idle(); iss_en = 1'b1; iss_dst = 3'd3;
    tick();
    idle(); srcB = 3'd3; rdB_en = 1'b1;
    tick();
    chk("busy3_byp", {31'd0, hazB_b}, 32'd1);
    chk("busy3_nob", {31'd0, hazB_n}, 32'd1);
    wrM = 1'b1; dstM = 3'd3; valM = 32'h33;
    tick();
    chk("clr3_byp", {31'd0, hazB_b}, 32'd0);
    chk("clr3_nob", {31'd0, hazB_n}, 32'd1);
    chk("clr3_val", valB_b, 32'h33);
    wrM = 1'b0;
    tick();
    chk("after3", {31'd0, hazB_n}, 32'd0);

    // issue and write to the same register: set wins
    idle(); iss_en = 1'b1; iss_dst = 3'd4; wrE = 1'b1; dstE = 3'd4; valE = 32'h44;
    tick();
    idle(); srcA = 3'd4; rdA_en = 1'b1;
    tick();
    chk("setwin_byp", {31'd0, hazA_b}, 32'd1);
    chk("setwin_nob", {31'd0, hazA_n}, 32'd1);

    // stall holds read outputs while the write still commits
    idle(); wrE = 1'b1; dstE = 3'd6; valE = 32'h11;
    tick();
    idle(); srcA = 3'd6; rdA_en = 1'b1;
    tick();
    chk("pre_stall", valA_b, 32'h11);
    stall = 1'b1; wrE = 1'b1; dstE = 3'd6; valE = 32'h22;
    tick();
    chk("stall1_byp", valA_b, 32'h11);
    wrE = 1'b0; dbg_addr = 3'd6;
    tick();
    chk("stall2_nob", valA_n, 32'h11);
    chk("stall_dbg", dbg_n, 32'h22);
    stall = 1'b0;
    tick();
    chk("unstall", valA_n, 32'h22);

    // disabled port reads zero even on a busy register
    idle(); iss_en = 1'b1; iss_dst = 3'd6;
    tick();
    idle(); srcA = 3'd6; rdA_en = 1'b0; srcB = 3'd6; rdB_en = 1'b1;
    tick();
    chk("dis_hazA", {31'd0, hazA_b}, 32'd0);
    chk("dis_valA", valA_b, 32'd0);
    chk("en_hazB", {31'd0, hazB_b}, 32'd1);

    // dual writes to different registers
    idle(); wrE = 1'b1; dstE = 3'd0; valE = 32'hA0; wrM = 1'b1; dstM = 3'd1; valM = 32'hB1;
    srcA = 3'd0; rdA_en = 1'b1; srcB = 3'd1; rdB_en = 1'b1;
    tick();
    chk("dual_A", valA_b, 32'hA0);
    chk("dual_B", valB_b, 32'hB1);
    chk("dual_Bn", valB_n, 32'h0);

    // fill everything, mark 7 busy, then reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      idle(); wrE = 1'b1; dstE = 3'(2 * i); valE = 32'hFFFFFFFF;
      wrM = 1'b1; dstM = 3'(2 * i + 1); valM = 32'hFFFFFFFF;
      tick();
    end
    idle(); iss_en = 1'b1; iss_dst = 3'd7;
    tick();
    idle(); srcA = 3'd7; rdA_en = 1'b1; srcB = 3'd0; rdB_en = 1'b1; dbg_addr = 3'd3;
    tick();
    chk("full_valA", valA_b, 32'hFFFFFFFF);
    chk("full_hazA", {31'd0, hazA_b}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_valA", valA_b, 32'd0);
    chk("arst_valB", valB_n, 32'd0);
    chk("arst_haz", {31'd0, hazA_b}, 32'd0);
    chk("arst_dbg", dbg_b, 32'd0);
    wrE = 1'b1; dstE = 3'd1; valE = 32'hDEAD; iss_en = 1'b1; iss_dst = 3'd1;
    tick();
    tick();
    idle(); srcA = 3'd7; rdA_en = 1'b1; srcB = 3'd1; rdB_en = 1'b1; dbg_addr = 3'd1;
    reset = 1'b1;
    tick();
    chk("post_haz7", {31'd0, hazA_b}, 32'd0);
    chk("post_val7", valA_n, 32'd0);
    chk("post_dbg1", dbg_b, 32'd0);
    chk("post_haz1", {31'd0, hazB_n}, 32'd0);
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
